conv_ctrl: RTL and testbench

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_ctrl_fetch.sv | 78 +++++++
 rtl/conv_ctrl.sv | 148 ++++++++++++++
 tb/tb_conv_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding and geometry helpers for the convolution controller.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StRun,
        StFin
    } conv_state_e;

    localparam int unsigned NWGT_DEFAULT = 9;
    localparam int unsigned CNT_W        = 16;

    // Padded image edge length.
    function automatic int unsigned conv_size(input int unsigned img, input int unsigned pad);
        return img + 2 * pad;
    endfunction

    // Words fetched per job: weights followed by the unpadded image.
    function automatic int unsigned conv_nw(input int unsigned nwgt, input int unsigned img);
        return nwgt + img * img;
    endfunction

    // Pooled results expected per job.
    function automatic int unsigned conv_npool(input int unsigned img, input int unsigned pad);
        int unsigned edge_len;
        edge_len = conv_size(img, pad) / 2 - 1;
        return edge_len * edge_len;
    endfunction

endpackage

// File: rtl/conv_ctrl_fetch.sv
// Source-memory reader: issues NW contiguous reads and presents the returned words to the
// datapath with weight/image load strobes aligned to the first weight and first image word.
module conv_ctrl_fetch
    import conv_pkg::*;
#(
    parameter int unsigned NWGT = NWGT_DEFAULT,
    parameter int unsigned NW   = 58
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch,
    input  logic [CNT_W-1:0] mem_data,
    output logic             mem_rd_en,
    output logic [CNT_W-1:0] mem_addr,
    output logic [CNT_W-1:0] img_in,
    output logic             w_load,
    output logic             i_load,
    output logic             last_word
);

    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(NW - 1);
    localparam logic [CNT_W-1:0] ILOAD_ADDR = CNT_W'(NWGT);

    logic             rd_en_q, rd_en_d;
    logic [CNT_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] img_q, img_d;
    logic             w_load_q, w_load_d;
    logic             i_load_q, i_load_d;
    logic             last_q, last_d;

    always_comb begin
        rd_en_d = rd_en_q;
        addr_d  = addr_q;
        if (launch) begin
            rd_en_d = 1'b1;
            addr_d  = '0;
        end else if (rd_en_q) begin
            if (addr_q == LAST_ADDR) begin
                rd_en_d = 1'b0;
                addr_d  = '0;
            end else begin
                addr_d = addr_q + CNT_W'(1);
            end
        end

        // Word addressed in this cycle is captured at the closing edge and shown next cycle.
        img_d    = rd_en_q ? mem_data : '0;
        w_load_d = rd_en_q && (addr_q == '0);
        i_load_d = rd_en_q && (addr_q == ILOAD_ADDR);
        last_d   = rd_en_q && (addr_q == LAST_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            img_q    <= '0;
            w_load_q <= 1'b0;
            i_load_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            img_q    <= img_d;
            w_load_q <= w_load_d;
            i_load_q <= i_load_d;
            last_q   <= last_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign img_in    = img_q;
    assign w_load    = w_load_q;
    assign i_load    = i_load_q;
    assign last_word = last_q;

endmodule

// File: rtl/conv_ctrl.sv
// Convolution job controller: job FSM, result-write counter and optional RUN watchdog
// (enabled by defining CONV_CTRL_WATCHDOG_EN).
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG     = 7,
    parameter int unsigned PAD     = 1,
    parameter int unsigned NWGT    = NWGT_DEFAULT,
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_rd_en,
    output logic [CNT_W-1:0] mem_addr,
    input  logic [CNT_W-1:0] mem_data,
    output logic             w_load,
    output logic             i_load,
    output logic [CNT_W-1:0] img_in,
    input  logic             done_pooling,
    input  logic [CNT_W-1:0] pool_out,
    output logic             res_we,
    output logic [CNT_W-1:0] res_addr,
    output logic [CNT_W-1:0] res_data
);

    localparam int unsigned      NW       = conv_nw(NWGT, IMG);
    localparam int unsigned      NPOOL    = conv_npool(IMG, PAD);
    localparam logic [CNT_W-1:0] LAST_RES = CNT_W'(NPOOL - 1);

    conv_state_e      state_q, state_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             err_q, err_d;
    logic             launch;
    logic             last_word;
    logic             wd_hit;

    conv_ctrl_fetch #(
        .NWGT (NWGT),
        .NW   (NW)
    ) u_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (launch),
        .mem_data  (mem_data),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .img_in    (img_in),
        .w_load    (w_load),
        .i_load    (i_load),
        .last_word (last_word)
    );

`ifdef CONV_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] wd_q, wd_d;

    // Held at zero outside RUN, so RUN entry always starts a fresh count.
    always_comb begin
        wd_d = '0;
        if (state_q == StRun && !done_pooling) begin
            wd_d = wd_q + CNT_W'(1);
        end
    end

    assign wd_hit = (state_q == StRun) && !done_pooling && (wd_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign wd_hit     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        res_cnt_d = res_cnt_q;
        err_d     = err_q;
        launch    = 1'b0;
        res_we    = 1'b0;
        res_addr  = '0;
        res_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StFetch;
                    launch    = 1'b1;
                    res_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            StFetch: begin
                if (last_word) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (done_pooling) begin
                    res_we    = 1'b1;
                    res_addr  = res_cnt_q;
                    res_data  = pool_out;
                    res_cnt_d = res_cnt_q + CNT_W'(1);
                    if (res_cnt_q == LAST_RES) begin
                        state_d = StFin;
                    end
                end else if (wd_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            res_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_cnt_q <= res_cnt_d;
            err_q     <= err_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StFin);
    // The timeout cycle itself already reports the error.
    assign err  = err_q | wd_hit;

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: fetch timing table, result writes, ignored starts, reset
// abandonment and (when CONV_CTRL_WATCHDOG_EN is defined) the RUN watchdog.
module tb_conv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        w_load;
    logic        i_load;
    logic [15:0] img_in;
    logic        done_pooling;
    logic [15:0] pool_out;
    logic        res_we;
    logic [15:0] res_addr;
    logic [15:0] res_data;

    int n_pass  = 0;
    int n_total = 0;

    // Source memory answers with address+100; the DUT captures it at the read cycle's edge.
    assign mem_data = mem_addr + 16'd100;

    conv_ctrl #(
        .IMG     (7),
        .PAD     (1),
        .NWGT    (9),
        .TMO_CYC (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .w_load       (w_load),
        .i_load       (i_load),
        .img_in       (img_in),
        .done_pooling (done_pooling),
        .pool_out     (pool_out),
        .res_we       (res_we),
        .res_addr     (res_addr),
        .res_data     (res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic        start;
        logic        dp;
        logic [15:0] pool;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        wl;
        logic        il;
        logic [15:0] img;
        logic        we;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    function automatic vec_t mk(input int cyc, input int s, input int dp, input int pool,
                                input int bz, input int rd, input int addr, input int wl,
                                input int il, input int img, input int we);
        vec_t v;
        v.cyc   = cyc;
        v.start = 1'(s);
        v.dp    = 1'(dp);
        v.pool  = 16'(pool);
        v.busy  = 1'(bz);
        v.rd    = 1'(rd);
        v.addr  = 16'(addr);
        v.wl    = 1'(wl);
        v.il    = 1'(il);
        v.img   = 16'(img);
        v.we    = 1'(we);
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Advance to just after the next rising edge and return inputs to their idle values.
    task automatic tick();
        @(posedge clk);
        #2;
        start        = 1'b0;
        done_pooling = 1'b0;
        pool_out     = 16'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_done"}, 16'(done), 16'd0);
        chk({tag, "_err"}, 16'(err), 16'd0);
        chk({tag, "_rd_en"}, 16'(mem_rd_en), 16'd0);
        chk({tag, "_addr"}, mem_addr, 16'd0);
        chk({tag, "_wl"}, 16'(w_load), 16'd0);
        chk({tag, "_il"}, 16'(i_load), 16'd0);
        chk({tag, "_img"}, img_in, 16'd0);
        chk({tag, "_res_we"}, 16'(res_we), 16'd0);
        chk({tag, "_res_addr"}, res_addr, 16'd0);
        chk({tag, "_res_data"}, res_data, 16'd0);
    endtask

    initial begin
        int vi;
        int seq_bad;

        // cyc, start, dp, pool | busy, rd, addr, wl, il, img, we  (cycle 0 = start cycle T)
        vecs[0]  = mk(0,  1, 0, 0,  0, 0, 0,  0, 0, 0,   0);
        vecs[1]  = mk(1,  0, 0, 0,  1, 1, 0,  0, 0, 0,   0);
        vecs[2]  = mk(2,  0, 0, 0,  1, 1, 1,  1, 0, 100, 0);
        vecs[3]  = mk(3,  0, 0, 0,  1, 1, 2,  0, 0, 101, 0);
        vecs[4]  = mk(5,  1, 0, 0,  1, 1, 4,  0, 0, 103, 0);
        vecs[5]  = mk(6,  0, 0, 0,  1, 1, 5,  0, 0, 104, 0);
        vecs[6]  = mk(10, 0, 0, 0,  1, 1, 9,  0, 0, 108, 0);
        vecs[7]  = mk(11, 0, 0, 0,  1, 1, 10, 0, 1, 109, 0);
        vecs[8]  = mk(12, 0, 0, 0,  1, 1, 11, 0, 0, 110, 0);
        vecs[9]  = mk(30, 0, 1, 77, 1, 1, 29, 0, 0, 128, 0);
        vecs[10] = mk(58, 0, 0, 0,  1, 1, 57, 0, 0, 156, 0);
        vecs[11] = mk(59, 0, 0, 0,  1, 0, 0,  0, 0, 157, 0);
        vecs[12] = mk(60, 0, 0, 0,  1, 0, 0,  0, 0, 0,   0);

        rst_n        = 1'b0;
        start        = 1'b0;
        done_pooling = 1'b0;
        pool_out     = 16'd0;
        tick();
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fetch phase, table driven, with a contiguous-address check on every cycle.
        vi      = 0;
        seq_bad = 0;
        for (int c = 0; c <= 60; c++) begin
            tick();
            if (vi < NV && vecs[vi].cyc == c) begin
                start        = vecs[vi].start;
                done_pooling = vecs[vi].dp;
                pool_out     = vecs[vi].pool;
            end
            #1;
            if (c >= 1 && c <= 58) begin
                if (mem_rd_en !== 1'b1 || mem_addr !== 16'(c - 1)) seq_bad++;
            end else if (mem_rd_en !== 1'b0) begin
                seq_bad++;
            end
            if (vi < NV && vecs[vi].cyc == c) begin
                chk($sformatf("busy@%0d", c), 16'(busy), 16'(vecs[vi].busy));
                chk($sformatf("rd_en@%0d", c), 16'(mem_rd_en), 16'(vecs[vi].rd));
                if (vecs[vi].rd) chk($sformatf("addr@%0d", c), mem_addr, vecs[vi].addr);
                chk($sformatf("w_load@%0d", c), 16'(w_load), 16'(vecs[vi].wl));
                chk($sformatf("i_load@%0d", c), 16'(i_load), 16'(vecs[vi].il));
                chk($sformatf("img_in@%0d", c), img_in, vecs[vi].img);
                chk($sformatf("res_we@%0d", c), 16'(res_we), 16'(vecs[vi].we));
                chk($sformatf("done@%0d", c), 16'(done), 16'd0);
                vi++;
            end
        end
        chk("rd_seq_bad_cycles", 16'(seq_bad), 16'd0);

        // RUN: nine pooled results with irregular gaps.
        for (int i = 0; i < 9; i++) begin
            repeat (i % 3) begin
                tick();
                #1;
                chk($sformatf("gap_we_%0d", i), 16'(res_we), 16'd0);
            end
            tick();
            done_pooling = 1'b1;
            pool_out     = 16'(i + 1);
            #1;
            chk($sformatf("res_we_%0d", i), 16'(res_we), 16'd1);
            chk($sformatf("res_addr_%0d", i), res_addr, 16'(i));
            chk($sformatf("res_data_%0d", i), res_data, 16'(i + 1));
            chk($sformatf("run_done_%0d", i), 16'(done), 16'd0);
        end
        // FIN: done pulse; start and done_pooling here are ignored.
        tick();
        start        = 1'b1;
        done_pooling = 1'b1;
        pool_out     = 16'h55;
        #1;
        chk("fin_done", 16'(done), 16'd1);
        chk("fin_busy", 16'(busy), 16'd1);
        chk("fin_res_we", 16'(res_we), 16'd0);
        tick();
        done_pooling = 1'b1;
        #1;
        chk("post_fin_done", 16'(done), 16'd0);
        chk("post_fin_busy", 16'(busy), 16'd0);
        chk("idle_res_we", 16'(res_we), 16'd0);
        tick();
        #1;
        chk("fin_start_ignored_busy", 16'(busy), 16'd0);
        chk("fin_start_ignored_rd", 16'(mem_rd_en), 16'd0);

        // Asynchronous reset in the middle of a fetch.
        tick();
        start = 1'b1;
        repeat (20) tick();
        #1;
        chk("pre_rst_addr", mem_addr, 16'd19);
        rst_n        = 1'b0;
        done_pooling = 1'b1;
        pool_out     = 16'h55;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        #1;
        chk("after_rst_busy", 16'(busy), 16'd0);
        tick();
        start = 1'b1;
        tick();
        #1;
        chk("restart_rd", 16'(mem_rd_en), 16'd1);
        chk("restart_addr", mem_addr, 16'd0);
        tick();
        #1;
        chk("restart_wl", 16'(w_load), 16'd1);
        chk("restart_img", img_in, 16'd100);

        // Reset during RUN after some writes; the next job restarts at result index 0.
        repeat (58) tick();
        #1;
        chk("run2_busy", 16'(busy), 16'd1);
        chk("run2_img", img_in, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            done_pooling = 1'b1;
            pool_out     = 16'(k + 40);
        end
        #1;
        chk("run2_third_addr", res_addr, 16'd2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        repeat (60) tick();
        done_pooling = 1'b1;
        pool_out     = 16'h33;
        #1;
        chk("run3_res_we", 16'(res_we), 16'd1);
        chk("run3_res_addr", res_addr, 16'd0);
        chk("run3_res_data", res_data, 16'h33);

`ifdef CONV_CTRL_WATCHDOG_EN
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        repeat (60) tick();
        repeat (14) tick();
        #1;
        chk("wd_r15_err", 16'(err), 16'd0);
        chk("wd_r15_busy", 16'(busy), 16'd1);
        tick();
        #1;
        chk("wd_r16_err", 16'(err), 16'd1);
        chk("wd_r16_busy", 16'(busy), 16'd1);
        tick();
        #1;
        chk("wd_idle_busy", 16'(busy), 16'd0);
        chk("wd_idle_err", 16'(err), 16'd1);
        chk("wd_idle_done", 16'(done), 16'd0);
        tick();
        #1;
        chk("wd_sticky_err", 16'(err), 16'd1);
        chk("wd_sticky_done", 16'(done), 16'd0);
        tick();
        start = 1'b1;
        tick();
        #1;
        chk("wd_clear_err", 16'(err), 16'd0);
        chk("wd_clear_busy", 16'(busy), 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
